// File: rtl/subtractor_serial.sv
// Bit-serial two's-complement subtractor q = a - b, LSB first, one full-subtractor cell reused per bit.
// Define SUBTRACTOR_SAT_EN to saturate q on signed overflow; borrow/ovf always describe the wrapped result.
module subtractor_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             borrow,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;
    logic             last_bit;

    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    // Clamp toward the sign of the minuend when the wrapped difference overflowed.
    function automatic logic [WIDTH-1:0] sat_q(input logic [WIDTH-1:0] r,
                                               input logic             ov,
                                               input logic             neg);
        logic signed [WIDTH-1:0] max_pos;
        logic signed [WIDTH-1:0] max_neg;
        max_pos = {1'b0, {(WIDTH-1){1'b1}}};
        max_neg = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SUBTRACTOR_SAT_EN
        if (ov) begin
            return neg ? max_neg : max_pos;
        end
        return r;
`else
        if (ov && (max_pos == max_neg) && neg) begin
            return r;
        end
        return r;
`endif
    endfunction

    always_comb begin
        d_bit    = fs_diff(sa[0], sb[0], br);
        br_next  = fs_borrow(sa[0], sb[0], br);
        res_next = {d_bit, res[WIDTH-1:1]};
        ovf_next = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
        last_bit = (cnt == LAST_CNT);
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            q      <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                // One result bit per edge; results publish only on the final bit.
                S_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    br  <= br_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        q      <= sat_q(res_next, ovf_next, a_msb);
                        borrow <= br_next;
                        ovf    <= ovf_next;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial: directed cases plus random operands against an arithmetic model.
module tb_subtractor_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic         borrow;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] last_q;

    subtractor_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .borrow(borrow),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= (1 << (W-1))) ? v - (1 << W) : v;
    endfunction

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input int av, input int bv,
                         output logic [W-1:0] eq, output logic eb, output logic eo);
        int sd;
        sd = to_signed(av) - to_signed(bv);
        eb = (av < bv);
        eo = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
        eq = W'((av - bv) & ((1 << W) - 1));
`ifdef SUBTRACTOR_SAT_EN
        if (eo) eq = (to_signed(av) < 0) ? W'(1 << (W-1)) : W'((1 << (W-1)) - 1);
`endif
    endtask

    task automatic run_op(input int av, input int bv, input string tag);
        logic [W-1:0] eq;
        logic         eb;
        logic         eo;
        int           cycles;
        model(av, bv, eq, eb, eo);
        @(negedge clk);
        a = W'(av);
        b = W'(bv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_qhold"}, q, last_q);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({tag, "_lat"}, cycles, W);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_borrow"}, borrow, eb);
        chk({tag, "_ovf"}, ovf, eo);
        last_q = eq;
        @(posedge clk);
        #1;
        chk({tag, "_done_off"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] eq;
        logic eb;
        logic eo;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", q, 0);
        chk("rst_borrow", borrow, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        last_q = '0;
        @(negedge clk);
        rst = 1'b0;

        run_op(7, 3, "p7m3");
        run_op(3, 4, "p3m4");
        run_op(12, 5, "n4m5");
        run_op(4, 12, "p4mn4");
        run_op(9, 9, "equal");
        run_op(11, 0, "bzero");
        run_op(8, 1, "minneg");
        run_op(0, 15, "zmn1");

        // Second start while busy must be ignored.
        model(6, 2, eq, eb, eo);
        @(negedge clk);
        a = 4'd6;
        b = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 4'd15;
        b = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                chk("ign_q", q, eq);
            end
            @(posedge clk);
            #1;
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_idle", busy, 1'b0);
        last_q = eq;

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 4'd5;
        b = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_q", q, 0);
        chk("abort_borrow", borrow, 1'b0);
        chk("abort_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        last_q = '0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        run_op(4, 4, "post_abort");

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
